// File: rtl/mem_page_reader.sv
// mem_page_reader: drains the page just closed by the producer through a
// fixed-latency read port and streams it out with valid/ready backpressure.
`ifndef MEM_SIZE
`define MEM_SIZE 5
`endif

module mem_page_reader #(
    parameter int MEM_WIDTH  = 16,
    parameter int ADD_SIZE   = `MEM_SIZE,
    parameter int RD_LAT     = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en_proc,
    input  logic [1:0]           start,
    output logic [1:0]           done,
    input  logic [5:0]           number_in,
    output logic [ADD_SIZE:0]    read_add,
    input  logic [MEM_WIDTH-1:0] data_in,
    output logic [MEM_WIDTH-1:0] out_data,
    output logic                 out_valid,
    output logic                 out_last,
    input  logic                 out_ready
);
    localparam int PAGE = 1 << ADD_SIZE;
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int OW = $clog2(FIFO_DEPTH + 1);
    localparam logic [PW-1:0] PTR_MAX = PW'(FIFO_DEPTH - 1);

    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

    state_t state, state_n;

    logic              wr_page, rd_page, epoch, ovr_flag;
    logic [ADD_SIZE:0] cnt, idx, cnt_new;
    logic              acc, preempt, issue, is_last;
    logic              pop, push, credit_ok;
    int                inflight;

    logic              iss_v, iss_last, iss_ep;
    logic [RD_LAT-1:0] pv, pl, pe;

    logic [MEM_WIDTH-1:0]  f_data [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] f_last;
    logic [PW-1:0]         wp, rp;
    logic [OW-1:0]         occ;

    logic unused_start;
    assign unused_start = start[1];

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PTR_MAX) ? '0 : p + 1'b1;
    endfunction

    assign acc       = start[0] & en_proc;
    assign out_valid = (occ != '0);
    assign out_data  = f_data[rp];
    assign out_last  = out_valid & f_last[rp];
    assign pop       = out_valid & out_ready;
    assign done      = {ovr_flag, state == DONE};

    always_comb begin
        cnt_new = (ADD_SIZE+1)'(number_in);
        if (int'(number_in) > PAGE)
            cnt_new = (ADD_SIZE+1)'(PAGE);
    end

    // Only current-epoch reads will land in the FIFO, so only they hold credit.
    always_comb begin
        inflight = (iss_v && iss_ep == epoch) ? 1 : 0;
        for (int i = 0; i < RD_LAT; i++)
            if (pv[i] && pe[i] == epoch)
                inflight++;
        credit_ok = (inflight + int'(occ) - int'(pop)) < FIFO_DEPTH;
    end

    assign push = pv[RD_LAT-1] & (pe[RD_LAT-1] == epoch) & ~preempt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n = state;
        issue   = 1'b0;
        preempt = 1'b0;
        is_last = (idx == cnt - 1'b1);
        if (acc) begin
            preempt = (state == READ) || (state == DRAIN);
            if (cnt_new == '0)
                state_n = DONE;
            else if (cnt_new == (ADD_SIZE+1)'(1))
                state_n = DRAIN;
            else
                state_n = READ;
        end else begin
            unique case (state)
                IDLE: state_n = IDLE;
                READ: begin
                    if (en_proc && credit_ok) begin
                        issue = 1'b1;
                        if (is_last)
                            state_n = DRAIN;
                    end
                end
                DRAIN: if (pop && out_last) state_n = DONE;
                DONE:  state_n = IDLE;
                default: state_n = IDLE;
            endcase
        end
    end

    // Index 0 issues on the accepting edge itself so read_add is live at T+1.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_page  <= 1'b0;
            rd_page  <= 1'b0;
            epoch    <= 1'b0;
            ovr_flag <= 1'b0;
            cnt      <= '0;
            idx      <= '0;
            read_add <= '0;
            iss_v    <= 1'b0;
            iss_last <= 1'b0;
            iss_ep   <= 1'b0;
            pv       <= '0;
            pl       <= '0;
            pe       <= '0;
        end else begin
            iss_v <= 1'b0;
            if (acc) begin
                wr_page <= ~wr_page;
                rd_page <= wr_page;
                cnt     <= cnt_new;
                epoch   <= epoch ^ preempt;
                if (preempt)
                    ovr_flag <= 1'b1;
                if (cnt_new != '0) begin
                    read_add <= {wr_page, {ADD_SIZE{1'b0}}};
                    iss_v    <= 1'b1;
                    iss_last <= (cnt_new == (ADD_SIZE+1)'(1));
                    iss_ep   <= epoch ^ preempt;
                    idx      <= (ADD_SIZE+1)'(1);
                end
            end else if (issue) begin
                read_add <= {rd_page, idx[ADD_SIZE-1:0]};
                iss_v    <= 1'b1;
                iss_last <= is_last;
                iss_ep   <= epoch;
                idx      <= idx + 1'b1;
            end
            for (int i = RD_LAT - 1; i > 0; i--) begin
                pv[i] <= pv[i-1];
                pl[i] <= pl[i-1];
                pe[i] <= pe[i-1];
            end
            pv[0] <= iss_v;
            pl[0] <= iss_last;
            pe[0] <= iss_ep;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wp     <= '0;
            rp     <= '0;
            occ    <= '0;
            f_last <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++)
                f_data[i] <= '0;
        end else if (preempt) begin
            wp  <= '0;
            rp  <= '0;
            occ <= '0;
        end else begin
            if (push) begin
                f_data[wp] <= data_in;
                f_last[wp] <= pl[RD_LAT-1];
                wp         <= nxt(wp);
            end
            if (pop)
                rp <= nxt(rp);
            occ <= occ + OW'(push) - OW'(pop);
        end
    end

endmodule
